memreg_arbiter: RTL

- Round-robin arbiter sharing one W-bit storage register among N requesters.
- Grants exclusive ownership to one requester at a time, with a bounded hold time.
- Performs the owner's writes and acknowledges each one.
- Sits between the datapath units that update the shared value and the register contents they read back.

---
 rtl/memreg_arb_pkg.sv | 22 ++
 rtl/memreg_arbiter_rr_pick.sv | 32 +++
 rtl/memreg_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/memreg_arb_pkg.sv
// Shared types and constants for the round-robin shared-register arbiter.
package memreg_arb_pkg;

    // Arbiter FSM: either nobody owns the register or exactly one requester does.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam int DEF_W       = 8;
    localparam int DEF_N       = 4;
    localparam int DEF_MAXHOLD = 15;

    // Hold counter width; MAXHOLD is limited to 255 so 8 bits always suffice.
    localparam int HOLD_W = 8;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/memreg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after Ptr, wrapping.
module rr_pick
    import memreg_arb_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  Req,
    input  logic [IW-1:0] Ptr,
    output logic          Valid,
    output logic [IW-1:0] Idx
);

    logic [2*N-1:0] req2_s;

    assign req2_s = {Req, Req};

    // Scan the doubled request vector downward so the lowest position inside
    // the window [Ptr, Ptr+N) is the one that sticks.
    always_comb begin
        Valid = |Req;
        Idx   = '0;
        for (int i = 2*N-1; i >= 0; i--) begin
            if (req2_s[i] && (i >= int'(Ptr)) && (i < int'(Ptr) + N)) begin
                Idx = IW'((i >= N) ? (i - N) : i);
            end else begin
                Idx = Idx;
            end
        end
    end

endmodule

// File: rtl/memreg_arbiter.sv
// Round-robin arbiter granting exclusive, time-bounded ownership of one
// W-bit shared register to one of N requesters and performing its writes.
module memreg_arbiter
    import memreg_arb_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int N       = DEF_N,
    parameter int MAXHOLD = DEF_MAXHOLD
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [N-1:0]              Req,
    input  logic [N-1:0]              Wr,
    input  logic [N*W-1:0]            WrData,
    output logic [N-1:0]              Grant,
    output logic [N-1:0]              Ack,
    output logic                      WriteEn,
    output logic [W-1:0]              DataOut,
    output logic [idx_width(N)-1:0]   Owner,
    output logic                      Busy
);

    localparam int IW = idx_width(N);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAXHOLD - 1);

    arb_state_e        state_r, state_n;
    logic [IW-1:0]     owner_r, owner_n;
    logic [IW-1:0]     ptr_r, ptr_n;
    logic [HOLD_W-1:0] hold_r, hold_n;
    logic [W-1:0]      data_r, data_n;
    logic [N-1:0]      ack_r, ack_n;
    logic [N-1:0]      grant_r, grant_n;
    logic              busy_r;
    logic              wr_en_s;
    logic              pick_valid_s;
    logic [IW-1:0]     pick_idx_s;
    logic              own_req_s;
    logic              own_wr_s;
    logic [W-1:0]      own_data_s;
    logic [IW-1:0]     next_ptr_s;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .Req   (Req),
        .Ptr   (ptr_r),
        .Valid (pick_valid_s),
        .Idx   (pick_idx_s)
    );

    assign own_req_s  = Req[owner_r];
    assign own_wr_s   = Wr[owner_r];
    assign own_data_s = WrData[int'(owner_r)*W +: W];
    assign next_ptr_s = (owner_r == IW'(N - 1)) ? '0 : (owner_r + IW'(1));

    // Next-state logic: arbitration in IDLE; writes, release and timeout in OWN.
    // Release beats a same-cycle write; a write in the timeout cycle still commits.
    always_comb begin
        state_n = state_r;
        owner_n = owner_r;
        ptr_n   = ptr_r;
        hold_n  = hold_r;
        data_n  = data_r;
        ack_n   = '0;
        wr_en_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_n = OWN;
                    owner_n = pick_idx_s;
                    hold_n  = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            OWN: begin
                if (!own_req_s) begin
                    state_n = IDLE;
                    ptr_n   = next_ptr_s;
                end else begin
                    wr_en_s = own_wr_s;
                    if (own_wr_s) begin
                        data_n         = own_data_s;
                        ack_n[owner_r] = 1'b1;
                    end else begin
                        data_n = data_r;
                    end
                    if (hold_r == HOLD_LAST) begin
                        state_n = IDLE;
                        ptr_n   = next_ptr_s;
                    end else begin
                        hold_n = hold_r + HOLD_W'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Registered one-hot grant follows the next owner.
    always_comb begin
        grant_n = '0;
        if (state_n == OWN) begin
            grant_n[owner_n] = 1'b1;
        end else begin
            grant_n = '0;
        end
    end

    // State, pointer, counter, storage and output registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= IDLE;
            owner_r <= '0;
            ptr_r   <= '0;
            hold_r  <= '0;
            data_r  <= '0;
            ack_r   <= '0;
            grant_r <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            owner_r <= owner_n;
            ptr_r   <= ptr_n;
            hold_r  <= hold_n;
            data_r  <= data_n;
            ack_r   <= ack_n;
            grant_r <= grant_n;
            busy_r  <= (state_n == OWN);
        end
    end

    assign Grant   = grant_r;
    assign Ack     = ack_r;
    assign WriteEn = wr_en_s;
    assign DataOut = data_r;
    assign Owner   = owner_r;
    assign Busy    = busy_r;

endmodule
